// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: FSM encoding,
// the NOP word, and the {inst, pc_plus4} queue entry.
package ifq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } ifq_state_e;

   localparam logic [31:0] NOP_INST = 32'h0;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_plus4;
   } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch queue bus: decode redirect, imem req/ack, IF/ID drain side.
// master = fetch queue, slave = decode/imem/IF-ID environment.
interface inst_fetch_queue_if #(
   parameter int DEPTH = 4
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic          inst_valid;
   logic [31:0]   inst_out;
   logic [31:0]   pc_plus4_out;
   logic          inst_ready;
   logic [CW-1:0] count;

   modport master (
      input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
             count
   );

   modport slave (
      output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
             count
   );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Circular FIFO of fetch entries with clear/push/pop and head/count.
// Ports: clk_i, rst_ni, clear_i, push_i, pop_i, data_i, head_o, empty_o, count_o.
module inst_fifo
   import ifq_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  ifq_entry_t    data_i,
   output ifq_entry_t    head_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   // Pointers carry an extra wrap bit so full and empty differ.
   logic [AW:0] rd_q, wr_q;
   ifq_entry_t  mem_q [DEPTH];
   logic        full, do_push, do_pop;

   assign count_o = wr_q - rd_q;
   assign empty_o = (wr_q == rd_q);
   assign full    = (count_o == CW'(DEPTH));
   assign do_push = push_i & ~full;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q <= '0;
         wr_q <= '0;
      end else if (clear_i) begin
         rd_q <= '0;
         wr_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !clear_i) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues imem reads, buffers results.
// Ports: clock, reset (async active-low), bus (master side of the fetch bus).
module inst_fetch_queue
   import ifq_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clock,
   input  logic               reset,
   inst_fetch_queue_if.master bus
);

   localparam int          CW    = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH - 1);

   ifq_state_e    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   stale_q, stale_d;
   logic [CW-1:0] cnt;
   logic          empty;
   ifq_entry_t    head, wdata;
   logic          pop, push, ack_live, space;
   logic [CW:0]   occ;

   assign ack_live = (state_q == S_WAIT) & bus.imem_ack;
   assign pop      = ~empty & bus.inst_ready;
   assign push     = ack_live & ~bus.redirect;

   // Occupancy once this cycle's pop and push land; a new request is
   // only allowed if that still leaves a slot for its response.
   assign occ   = {1'b0, cnt} - (CW+1)'(pop) + (CW+1)'(ack_live);
   assign space = (occ <= LIMIT);

   assign wdata.inst     = bus.imem_rdata;
   assign wdata.pc_plus4 = pc_q + 32'd4;

   inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .clear_i (bus.redirect),
      .push_i  (push),
      .pop_i   (pop & ~bus.redirect),
      .data_i  (wdata),
      .head_o  (head),
      .empty_o (empty),
      .count_o (cnt)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         stale_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stale_q <= stale_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stale_d = stale_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.redirect) pc_d = bus.redirect_pc;
            else if (space)   state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.redirect) begin
               pc_d = bus.redirect_pc;
               if (bus.imem_ack) begin
                  state_d = S_IDLE;
               end else begin
                  // Request cannot be withdrawn; keep its address on the bus.
                  stale_d = pc_q;
                  state_d = S_DRAIN;
               end
            end else if (bus.imem_ack) begin
               pc_d    = pc_q + 32'd4;
               state_d = space ? S_WAIT : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (bus.redirect) pc_d = bus.redirect_pc;
            if (bus.imem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.imem_req     = (state_q != S_IDLE);
   assign bus.imem_addr    = (state_q == S_DRAIN) ? stale_q : pc_q;
   assign bus.inst_valid   = ~empty;
   assign bus.inst_out     = empty ? NOP_INST : head.inst;
   assign bus.pc_plus4_out = empty ? 32'h0 : head.pc_plus4;
   assign bus.count        = cnt;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue with a queue-based reference model.
// Directed scenarios pin the model with literal expectations.
module tb_inst_fetch_queue;
   import ifq_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc4;
   } ent_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   pass  = 0;

   always #5 clock = ~clock;

   inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign bus.imem_rdata = memf(bus.imem_addr);

   // Model: queue contents, fetch PC, and the outstanding request
   // (0 none, 1 live, 2 stale whose data will be thrown away).
   ent_t        mq[$];
   int          ost     = 0;
   logic [31:0] m_pc    = RPC;
   logic [31:0] m_stale = RPC;

   task automatic model_step();
      bit   pop;
      bit   skip;
      ent_t e;
      pop  = (mq.size() > 0) && bus.inst_ready;
      skip = 0;
      if (bus.redirect) begin
         mq.delete();
         if (ost == 1 && !bus.imem_ack) begin
            ost     = 2;
            m_stale = m_pc;
         end else if (bus.imem_ack) begin
            ost = 0;
         end
         m_pc = bus.redirect_pc;
      end else begin
         if (pop) void'(mq.pop_front());
         if (ost == 1 && bus.imem_ack) begin
            e.inst = memf(m_pc);
            e.pc4  = m_pc + 32'd4;
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
            ost  = 0;
         end else if (ost == 2 && bus.imem_ack) begin
            ost  = 0;
            skip = 1;
         end
         if (ost == 0 && !skip && mq.size() < DEPTH) ost = 1;
      end
   endtask

   initial forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
         mq.delete();
         ost     = 0;
         m_pc    = RPC;
         m_stale = RPC;
      end else begin
         model_step();
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic check_all();
      logic [31:0] ea;
      ea = (ost == 2) ? m_stale : m_pc;
      chk("req", 32'(bus.imem_req), 32'(ost != 0));
      if (ost != 0) chk("addr", bus.imem_addr, ea);
      chk("valid", 32'(bus.inst_valid), 32'(mq.size() > 0));
      chk("inst", bus.inst_out, mq.size() > 0 ? mq[0].inst : 32'h0);
      chk("pc4", bus.pc_plus4_out, mq.size() > 0 ? mq[0].pc4 : 32'h0);
      chk("count", 32'(bus.count), 32'(mq.size()));
   endtask

   task automatic tick();
      @(negedge clock);
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      logic [31:0] r;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.imem_ack    = 1'b0;
      bus.inst_ready  = 1'b0;

      // Reset state
      do_reset();
      chk("rst_req", 32'(bus.imem_req), 32'h0);
      chk("rst_addr", bus.imem_addr, RPC);
      chk("rst_count", 32'(bus.count), 32'h0);

      // Streaming with ack tied high
      bus.imem_ack   = 1'b1;
      bus.inst_ready = 1'b1;
      reset          = 1'b1;
      tick();
      chk("s_req", 32'(bus.imem_req), 32'h1);
      chk("s_addr0", bus.imem_addr, 32'h0);
      tick();
      chk("s_inst0", bus.inst_out, memf(32'h0));
      chk("s_pc4_4", bus.pc_plus4_out, 32'h4);
      tick();
      chk("s_addr8", bus.imem_addr, 32'h8);
      chk("s_pc4_8", bus.pc_plus4_out, 32'h8);
      tick();
      chk("s_pc4_c", bus.pc_plus4_out, 32'hC);

      // Fill up with no drain
      do_reset();
      bus.inst_ready = 1'b0;
      reset          = 1'b1;
      repeat (5) tick();
      chk("f_count4", 32'(bus.count), 32'h4);
      chk("f_req0", 32'(bus.imem_req), 32'h0);
      bus.inst_ready = 1'b1;
      tick();
      chk("f_resume", bus.imem_addr, 32'h10);
      chk("f_count3", 32'(bus.count), 32'h3);

      // Delayed ack holds the address
      do_reset();
      bus.inst_ready = 1'b0;
      reset          = 1'b1;
      tick();
      tick();
      tick();
      chk("d_addr8", bus.imem_addr, 32'h8);
      bus.imem_ack = 1'b0;
      repeat (3) begin
         tick();
         chk("d_hold", bus.imem_addr, 32'h8);
         chk("d_cnt2", 32'(bus.count), 32'h2);
      end
      bus.imem_ack = 1'b1;
      tick();
      chk("d_cnt3", 32'(bus.count), 32'h3);

      // Redirect while 0x0C pending without ack
      do_reset();
      bus.inst_ready = 1'b1;
      reset          = 1'b1;
      repeat (4) tick();
      chk("r_addrC", bus.imem_addr, 32'hC);
      bus.imem_ack    = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h40;
      tick();
      chk("r_valid0", 32'(bus.inst_valid), 32'h0);
      chk("r_stale", bus.imem_addr, 32'hC);
      bus.redirect = 1'b0;
      tick();
      bus.imem_ack = 1'b1;
      tick();
      chk("r_idle", 32'(bus.imem_req), 32'h0);
      tick();
      chk("r_new", bus.imem_addr, 32'h40);
      tick();
      chk("r_pc4", bus.pc_plus4_out, 32'h44);
      chk("r_inst", bus.inst_out, memf(32'h40));

      // Redirect coinciding with ack, count 2
      do_reset();
      bus.inst_ready = 1'b0;
      reset          = 1'b1;
      repeat (3) tick();
      chk("ra_cnt2", 32'(bus.count), 32'h2);
      bus.inst_ready  = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h100;
      tick();
      chk("ra_cnt0", 32'(bus.count), 32'h0);
      bus.redirect = 1'b0;
      tick();
      chk("ra_addr", bus.imem_addr, 32'h100);

      // Asynchronous reset mid-request
      do_reset();
      bus.inst_ready = 1'b0;
      reset          = 1'b1;
      repeat (4) tick();
      chk("ar_cnt3", 32'(bus.count), 32'h3);
      #2 reset = 1'b0;
      #1;
      chk("ar_req", 32'(bus.imem_req), 32'h0);
      chk("ar_addr", bus.imem_addr, RPC);
      chk("ar_valid", 32'(bus.inst_valid), 32'h0);
      chk("ar_inst", bus.inst_out, 32'h0);
      chk("ar_pc4", bus.pc_plus4_out, 32'h0);
      chk("ar_count", 32'(bus.count), 32'h0);
      tick();
      reset = 1'b1;
      tick();
      chk("ar_restart", bus.imem_addr, RPC);

      // Randomized traffic
      do_reset();
      reset = 1'b1;
      repeat (3000) begin
         bus.imem_ack   = ($urandom_range(0, 3) != 0);
         bus.inst_ready = ($urandom_range(0, 3) != 0);
         bus.redirect   = ($urandom_range(0, 15) == 0);
         r = $urandom();
         if ($urandom_range(0, 7) == 0) bus.redirect_pc = 32'hFFFF_FFF8;
         else bus.redirect_pc = {r[31:2], 2'b00};
         tick();
      end

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction-fetch front end for the five-stage MIPS pipeline, sitting directly upstream of the IF/ID register. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered, with their PC+4, in a small queue that the IF/ID register drains under the hazard unit's load enable. Branch and jump redirects from decode flush the queue and discard any in-flight fetch.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- redirect  in  1  decode-stage taken branch/jump/jr (pc_src ≠ 0)
- redirect_pc  in  32  target address, valid while redirect=1
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of the request; stable while imem_req=1
- imem_ack  in  1  read data valid this cycle; meaningful only when imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- inst_valid  out  1  queue head holds an instruction
- inst_out  out  32  head instruction; 32'h0 (NOP) when empty
- pc_plus4_out  out  32  head PC+4; 32'h0 when empty
- inst_ready  in  1  IF/ID load enable (hazard-unit IFID_Ld); pops the head when inst_valid=1
- count  out  log2(DEPTH)+1  current queue occupancy

## Operation
- Registers: fetch_pc (32), FSM state, queue (DEPTH × {inst, pc_plus4}).
- FSM states: IDLE (no request), WAIT (request outstanding), DRAIN (stale request outstanding; response is discarded).
- imem_req = 1 in WAIT and DRAIN; imem_addr = fetch_pc in WAIT, and the latched stale address in DRAIN.
- Space check: space = (count − pop + 1 ≤ DEPTH − 1 after accounting for the pending push), where pop = inst_valid & inst_ready. A request is started only if its response is guaranteed a free slot, so the queue never overflows.
- IDLE → WAIT when space is available; otherwise remain in IDLE.
- WAIT with imem_ack:
  - Push {imem_rdata, fetch_pc+4}.
  - fetch_pc += 4 (32-bit wrap, no flag).
  - Remain in WAIT if space is still available after this push and pop; otherwise go to IDLE.
- WAIT without ack: hold. A request is never withdrawn.
- Redirect (priority over push, pop and FSM):
  - Queue cleared and fetch_pc ← redirect_pc.
  - From WAIT with no ack in the same cycle: latch the old address and go to DRAIN.
  - From WAIT with ack in the same cycle: drop the data and go to IDLE.
  - From IDLE: stay in IDLE.
- DRAIN with imem_ack: discard the data and go to IDLE. A redirect during DRAIN only updates fetch_pc.
- Push and pop in the same cycle: both take effect, count is unchanged.
- Pop on empty: ignored.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, pc_plus4_out=0, count=0.
  - fetch_pc=RESET_PC, state=IDLE.
- First request is raised one cycle after reset deasserts.
- Ack at edge n → instruction visible on inst_out after edge n (inst_valid=1 in cycle n+1). No bypass.
- With single-cycle ack and continuous inst_ready: one instruction per cycle sustained.
- Redirect at edge n:
  - inst_valid=0 in cycle n+1.
  - The new target is requested in cycle n+1 (from IDLE) or the cycle after the stale ack (from DRAIN).
- Reset asserted mid-request: the request drops immediately (async); the memory must tolerate an abandoned request.

## Structure
- Package ifq_pkg holds:
  - FSM state encoding (IDLE/WAIT/DRAIN)
  - NOP_INST = 32'h0
  - fetch entry struct {inst, pc_plus4}
- Sub-module inst_fifo: synchronous DEPTH-entry circular FIFO with clear, push, pop, count and head outputs, using a registered head pointer and a wrap bit. The FSM and PC logic stay in the top module.

## Test plan
- Reset release, ack tied high, inst_ready=1 → addresses 0,4,8,… issued on consecutive cycles; inst_out follows one cycle behind each ack; pc_plus4_out = 4,8,12.
- inst_ready=0, DEPTH=4, ack tied high → exactly 4 pushes, count=4, imem_req=0; then raise inst_ready → fetch resumes at 0x10.
- Ack delayed 3 cycles → imem_addr stays at 0x8 for all 3 cycles; count unchanged until the ack.
- Redirect to 0x40 while a request to 0x0C is pending without ack → queue empties next cycle; the 0x0C data is discarded on its ack; the next request is to 0x40 with pc_plus4_out=0x44.
- Redirect and imem_ack in the same cycle with count=2 and inst_ready=1 → count=0, data dropped, next request is to redirect_pc.
- reset pulled low while imem_req=1 with count=3 → all outputs return to their reset values immediately; after release, fetch restarts at RESET_PC.
